// File: rtl/sort_pkg.sv
// Shared definitions for the sequential sorter: defaults, derived constants
// and the controller state encoding.
package sort_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DEPTH = 4;

  // Number of compare-exchange steps in one full bubble sort of a batch.
  function automatic int unsigned ncmp(input int unsigned depth);
    return depth * (depth - 1) / 2;
  endfunction

  localparam int unsigned NCMP = DEF_DEPTH * (DEF_DEPTH - 1) / 2;

  // Encodings kept identical to the legacy constants.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sort2.sv
// Combinational compare-exchange cell: out0 = min, out1 = max (unsigned).
module sort2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1
);

  // Swap only when in1 is strictly smaller; equal values pass straight through.
  always_comb begin
    if (in1 < in0) begin
      out0 = in1;
      out1 = in0;
    end else begin
      out0 = in0;
      out1 = in1;
    end
  end

endmodule

// File: rtl/sort4_seq.sv
// Sequential bubble sorter: load DEPTH values over a valid/ready stream,
// sort them in place one compare-exchange per clock, then stream them out
// smallest first.
module sort4_seq
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] LAST     = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LASTPASS = CW'(DEPTH - 2);

  state_t           state;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    pass;
  logic [CW-1:0]    rd;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    idx_nxt;
  logic [CW-1:0]    pass_end;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  // Neighbour index and the last compare position of the current pass.
  always_comb begin
    idx_nxt  = idx + ONE;
    pass_end = LASTPASS - pass;
  end

  sort2 #(.WIDTH(WIDTH)) u_sort2 (
    .in0  (mem[idx]),
    .in1  (mem[idx_nxt]),
    .out0 (lo),
    .out1 (hi)
  );

  // Handshake flags decode from registered state only.
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    busy      = (state != LOAD);
    out_data  = mem[rd];
  end

  // Controller, counters and buffer; reset discards the batch but not the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      idx   <= '0;
      pass  <= '0;
      rd    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            mem[idx] <= in_data;
            if (idx == LAST) begin
              idx   <= '0;
              pass  <= '0;
              state <= SORT;
            end else begin
              idx <= idx_nxt;
            end
          end
        end
        SORT: begin
          mem[idx]     <= lo;
          mem[idx_nxt] <= hi;
          if (idx == pass_end) begin
            idx <= '0;
            if (pass == LASTPASS) begin
              rd    <= '0;
              state <= DRAIN;
            end else begin
              pass <= pass + ONE;
            end
          end else begin
            idx <= idx_nxt;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd == LAST) begin
              idx   <= '0;
              state <= LOAD;
            end else begin
              rd <= rd + ONE;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_seq.sv
// Scoreboard bench for sort4_seq: the driver pushes the sorted batch when
// its last value is accepted, the monitor pops on every output handshake.
module tb_sort4_seq;

  localparam int W = 4;
  localparam int D = 4;
  localparam int NC = D * (D - 1) / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;

  logic fixed_ready;
  logic rnd_ready;
  logic rnd_bit;
  assign out_ready = rnd_ready ? rnd_bit : fixed_ready;

  sort4_seq #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: repeatedly take the smallest remaining value.
  task automatic push_sorted(input int vals[D]);
    int pool[$];
    int mi;
    for (int i = 0; i < D; i++) pool.push_back(vals[i]);
    while (pool.size() > 0) begin
      mi = 0;
      for (int j = 1; j < pool.size(); j++)
        if (pool[j] < pool[mi]) mi = j;
      exp_q.push_back(pool[mi]);
      pool.delete(mi);
    end
  endtask

  task automatic load_batch(input int vals[D], input int gap);
    bit hs;
    int guard;
    for (int i = 0; i < D; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = W'(vals[i]);
      guard = 0;
      hs = 1'b0;
      while (!hs && guard < 300) begin
        @(negedge clk);
        hs = in_ready && !reset;
        @(posedge clk); #1;
        guard++;
      end
      if (!hs) check("load_timeout", 0, 1);
    end
    in_valid = 1'b0;
    push_sorted(vals);
  endtask

  // Monitor state
  int  ld_cnt = 0;
  int  out_cnt = 0;
  int  last_hs = -1000;
  bit  prev_ov = 1'b0;
  bit  hold_pend = 1'b0;
  bit  done_pend = 1'b0;
  int  held = 0;
  int  exp_v;

  always @(negedge clk) begin
    if (reset) begin
      ld_cnt = 0; out_cnt = 0; last_hs = -1000;
      prev_ov = 1'b0; hold_pend = 1'b0; done_pend = 1'b0;
    end else begin
      if (done_pend) begin
        check("in_ready_after_drain", int'(in_ready), 1);
        check("out_valid_after_drain", int'(out_valid), 0);
        done_pend = 1'b0;
      end
      if (hold_pend) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), held);
      end
      if (cyc > last_hs && cyc <= last_hs + NC) begin
        check("sort_in_ready", int'(in_ready), 0);
        check("sort_out_valid", int'(out_valid), 0);
        check("sort_busy", int'(busy), 1);
      end
      if (out_valid && !prev_ov)
        check("first_out_latency", cyc - last_hs, NC + 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(out_data), -1);
        end else begin
          exp_v = exp_q.pop_front();
          check("out_data", int'(out_data), exp_v);
        end
        out_cnt++;
        if (out_cnt == D) begin
          done_pend = 1'b1;
          out_cnt = 0;
        end
      end
      hold_pend = out_valid && !out_ready;
      held = int'(out_data);
      if (in_valid && in_ready) begin
        ld_cnt++;
        if (ld_cnt == D) begin
          last_hs = cyc;
          ld_cnt = 0;
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic wait_drained();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  int  b[D];
  bit  seen;
  int  guard;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    fixed_ready = 1'b1; rnd_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // Basic batch
    b = '{15, 0, 10, 5};
    load_batch(b, 0);
    wait_drained();

    // Duplicates
    b = '{3, 3, 0, 3};
    load_batch(b, 0);
    wait_drained();

    // Reverse order then already sorted
    b = '{15, 14, 13, 12};
    load_batch(b, 0);
    b = '{1, 2, 3, 4};
    load_batch(b, 0);
    wait_drained();

    // Backpressure at start of DRAIN with ignored input 1000
    fixed_ready = 1'b0;
    b = '{6, 2, 9, 4};
    load_batch(b, 0);
    in_valid = 1'b1;
    in_data  = 4'd8;
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 50) begin
      @(negedge clk);
      seen = out_valid;
      guard++;
    end
    if (!seen) check("drain_start_timeout", 0, 1);
    repeat (4) @(negedge clk);
    fixed_ready = 1'b1;
    in_valid = 1'b0;
    wait_drained();

    // Reset during 3rd SORT cycle
    b = '{9, 1, 14, 7};
    load_batch(b, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_in_ready", int'(in_ready), 1);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_busy", int'(busy), 0);
    @(posedge clk); #1;
    b = '{7, 1, 4, 2};
    load_batch(b, 0);
    wait_drained();

    // Input gaps
    b = '{5, 11, 0, 8};
    load_batch(b, 3);
    wait_drained();

    // Randomized batches with random gaps and random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < D; i++) b[i] = int'($urandom_range(0, (1 << W) - 1));
      load_batch(b, int'($urandom_range(0, 2)));
    end
    wait_drained();
    rnd_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sort4_seq.md
# sort4_seq

Sequential sorter that accepts DEPTH unsigned WIDTH-bit values over a valid/ready stream, sorts them in place by bubble sort, and streams them out in ascending order. It reuses the existing combinational `sort2` compare-exchange cell, one evaluation per clock. It is the stream-level producer/consumer wrapper around `sort2`: upstream logic writes unsorted samples in, and downstream logic reads sorted samples out.

## Interface
- WIDTH, 4, bit width of each value; values are unsigned.
- DEPTH, 4, number of values per batch; must be at least 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a value on in_data.
- in_data  input  WIDTH  value to load.
- in_ready  output  1  block accepts a value this cycle.
- out_valid  output  1  out_data holds a sorted value.
- out_data  output  WIDTH  sorted value; smallest is emitted first.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  high while in SORT or DRAIN.

## Operation
- Storage: DEPTH×WIDTH register buffer `buf`, plus counters `idx`, `pass` and `rd`.
- State LOAD:
  - in_ready = 1.
  - A handshake (in_valid & in_ready) writes buf[idx] and increments idx.
  - On the DEPTH-th handshake, go to SORT with idx = 0 and pass = 0.
- State SORT:
  - in_ready = 0 and out_valid = 0.
  - Each cycle, `sort2` receives buf[idx] and buf[idx+1]; its out0 (min) is written to buf[idx] and out1 (max) to buf[idx+1].
  - idx increments until it reaches DEPTH-2-pass. Then idx returns to 0 and pass increments.
  - After pass DEPTH-2 completes, go to DRAIN with rd = 0.
  - SORT always runs exactly DEPTH(DEPTH-1)/2 cycles. There is no early exit on already-sorted data.
- State DRAIN:
  - out_valid = 1 and out_data = buf[rd].
  - A handshake (out_valid & out_ready) increments rd.
  - The handshake at rd = DEPTH-1 returns to LOAD with idx = 0.
- Comparison is unsigned. On equal values `sort2` may pass them through in either order; the output is identical either way.
- in_valid outside LOAD is ignored; no value is captured.
- Loading and draining never overlap. The block does not accept new input while draining.
- reset asserted in any state:
  - next state LOAD; idx, pass and rd = 0;
  - buffer contents are discarded (they need not be cleared);
  - no handshake is honoured in a cycle where reset is high.

## Timing
- Reset values: state LOAD, in_ready = 1, out_valid = 0, busy = 0. out_data is don't-care while out_valid = 0.
- in_ready, out_valid and busy decode from registered state only. There are no combinational paths from in_valid or out_ready.
- Latency: if the last input handshake occurs in cycle T, SORT occupies cycles T+1 through T+DEPTH(DEPTH-1)/2, and out_valid first rises in cycle T+DEPTH(DEPTH-1)/2+1. With DEPTH = 4 that is T+7.
- Backpressure: while out_valid & !out_ready, out_data and rd hold.
- Throughput:
  - with in_valid and out_ready held high, one batch completes every DEPTH + DEPTH(DEPTH-1)/2 + DEPTH cycles, which is 14 for DEPTH = 4;
  - in_ready rises in the cycle after the final output handshake.
- Gaps in in_valid during LOAD only stall idx; partial batches persist indefinitely.

## Structure
- Shared package `sort_pkg`:
  - state encoding LOAD/SORT/DRAIN;
  - default WIDTH/DEPTH constants;
  - the derived constant NCMP = DEPTH(DEPTH-1)/2.
- Sub-module `sort2`, one instance, existing contract: out0 = min(in0, in1) and out1 = max(in0, in1), combinational, WIDTH-bit unsigned.
- Counter widths: $clog2(DEPTH). Everything else is flat in `sort4_seq`.

## Test plan
- Basic batch:
  - stimulus: reset for 2 cycles, then load 1111, 0000, 1010, 0101 back-to-back with out_ready = 1;
  - response: out_data sequence 0000, 0101, 1010, 1111; out_valid first high 7 cycles after the last input handshake; in_ready = 1 again after the fourth output.
- Duplicates:
  - stimulus: load 0011, 0011, 0000, 0011;
  - response: outputs 0000, 0011, 0011, 0011.
- Reverse order, then already sorted:
  - stimulus: load 1111, 1110, 1101, 1100, then 0001, 0010, 0011, 0100;
  - response: 1100, 1101, 1110, 1111, then 0001, 0010, 0011, 0100; both batches take the full 6 SORT cycles.
- Backpressure and ignored input:
  - stimulus: hold out_ready = 0 for 5 cycles at the start of DRAIN while driving in_valid = 1 with in_data = 1000;
  - response: out_data holds its first value (the batch minimum); no output is lost or repeated; 1000 never appears in the output.
- Reset mid-operation:
  - stimulus: assert reset during the 3rd SORT cycle;
  - response: in the next cycle in_ready = 1, out_valid = 0 and busy = 0; a fresh batch 0111, 0001, 0100, 0010 yields 0001, 0010, 0100, 0111.
- Input gaps:
  - stimulus: insert 3 idle cycles between each in_valid;
  - response: no extra captures and correct sorted output.
